// File: rtl/slc3_pkg.sv
// rtl/slc3_pkg.sv - SLC-3 control FSM states, opcodes and control encodings
package slc3_pkg;

  typedef enum logic [4:0] {
    HALTED, FETCH1, FETCH2, FETCH3, DECODE, ALU, BR0, BR1, JMP,
    JSR1, JSR2, LDR1, LDR2, LDR3, STR1, STR2, STR3, PAUSE1, PAUSE2
  } state_t;

  localparam logic [3:0] OP_BR    = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_JSR   = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_LDR   = 4'b0110;
  localparam logic [3:0] OP_STR   = 4'b0111;
  localparam logic [3:0] OP_NOT   = 4'b1001;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_PAUSE = 4'b1101;

  localparam logic [1:0] ALUK_ADD  = 2'b00;
  localparam logic [1:0] ALUK_AND  = 2'b01;
  localparam logic [1:0] ALUK_NOT  = 2'b10;
  localparam logic [1:0] ALUK_PASS = 2'b11;

  localparam logic [1:0] PCMUX_PC1   = 2'b00;
  localparam logic [1:0] PCMUX_ADDER = 2'b10;

  localparam logic [1:0] A2_ZERO  = 2'b00;
  localparam logic [1:0] A2_OFF6  = 2'b01;
  localparam logic [1:0] A2_OFF9  = 2'b10;
  localparam logic [1:0] A2_OFF11 = 2'b11;

  function automatic logic [1:0] alu_op(input logic [3:0] op);
    case (op)
      OP_AND:  alu_op = ALUK_AND;
      OP_NOT:  alu_op = ALUK_NOT;
      default: alu_op = ALUK_ADD;
    endcase
  endfunction

endpackage

// File: rtl/slc3_mem_wait.sv
// rtl/slc3_mem_wait.sv - shared SRAM wait-state counter for read/write strobes
module slc3_mem_wait #(
  parameter int MEM_WAIT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  output logic done
);

  logic [3:0] wait_cnt;

  assign done = active && (wait_cnt == 4'(MEM_WAIT - 1));

  // Clearing on done as well as when idle guarantees every memory state starts at 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wait_cnt <= 4'd0;
    else if (!active || done)
      wait_cnt <= 4'd0;
    else
      wait_cnt <= wait_cnt + 4'd1;
  end

endmodule

// File: rtl/slc3_isdu.sv
// rtl/slc3_isdu.sv - SLC-3 instruction sequencing and decode control FSM
module slc3_isdu
  import slc3_pkg::*;
#(
  parameter int MEM_WAIT = 2
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Run,
  input  logic        Continue,
  input  logic [15:0] IR,
  input  logic        BEN,
  output logic        LD_MAR,
  output logic        LD_MDR,
  output logic        LD_IR,
  output logic        LD_BEN,
  output logic        LD_CC,
  output logic        LD_REG,
  output logic        LD_PC,
  output logic        LD_LED,
  output logic        GatePC,
  output logic        GateMDR,
  output logic        GateALU,
  output logic        GateMARMUX,
  output logic [1:0]  PCMUX,
  output logic        DRMUX,
  output logic        SR1MUX,
  output logic        SR2MUX,
  output logic        ADDR1MUX,
  output logic [1:0]  ADDR2MUX,
  output logic [1:0]  ALUK,
  output logic        MIO_EN,
  output logic        Mem_OE_n,
  output logic        Mem_WE_n
);

  state_t state, next_state;
  logic   mem_active, mem_done;
  logic   unused_ir;

  assign unused_ir  = ^{IR[10:6], IR[4:0]};
  assign mem_active = (state == FETCH2) || (state == LDR2) || (state == STR3);

  slc3_mem_wait #(.MEM_WAIT(MEM_WAIT)) u_wait (
    .clk    (Clk),
    .rst_n  (Reset_n),
    .active (mem_active),
    .done   (mem_done)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)
      state <= HALTED;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    LD_MAR = 1'b0; LD_MDR = 1'b0; LD_IR = 1'b0; LD_BEN = 1'b0;
    LD_CC = 1'b0; LD_REG = 1'b0; LD_PC = 1'b0; LD_LED = 1'b0;
    GatePC = 1'b0; GateMDR = 1'b0; GateALU = 1'b0; GateMARMUX = 1'b0;
    PCMUX = PCMUX_PC1; DRMUX = 1'b0; SR1MUX = 1'b0; SR2MUX = 1'b0;
    ADDR1MUX = 1'b0; ADDR2MUX = A2_ZERO; ALUK = ALUK_ADD;
    MIO_EN = 1'b0; Mem_OE_n = 1'b1; Mem_WE_n = 1'b1;

    case (state)
      HALTED: if (Run) next_state = FETCH1;
      FETCH1: begin
        GatePC = 1'b1; LD_MAR = 1'b1; PCMUX = PCMUX_PC1; LD_PC = 1'b1;
        next_state = FETCH2;
      end
      FETCH2, LDR2: begin
        Mem_OE_n = 1'b0; MIO_EN = 1'b1;
        if (mem_done) begin
          LD_MDR = 1'b1;
          next_state = (state == FETCH2) ? FETCH3 : LDR3;
        end
      end
      FETCH3: begin
        GateMDR = 1'b1; LD_IR = 1'b1;
        next_state = DECODE;
      end
      DECODE: begin
        LD_BEN = 1'b1;
        case (IR[15:12])
          OP_ADD, OP_AND, OP_NOT: next_state = ALU;
          OP_BR:    next_state = BR0;
          OP_JMP:   next_state = JMP;
          OP_JSR:   next_state = JSR1;
          OP_LDR:   next_state = LDR1;
          OP_STR:   next_state = STR1;
          OP_PAUSE: next_state = PAUSE1;
          default:  next_state = FETCH1;
        endcase
      end
      ALU: begin
        SR1MUX = 1'b1; SR2MUX = IR[5]; ALUK = alu_op(IR[15:12]);
        GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
        next_state = FETCH1;
      end
      BR0: next_state = BEN ? BR1 : FETCH1;
      BR1: begin
        ADDR2MUX = A2_OFF9; PCMUX = PCMUX_ADDER; LD_PC = 1'b1;
        next_state = FETCH1;
      end
      JMP: begin
        SR1MUX = 1'b1; ADDR1MUX = 1'b1; ADDR2MUX = A2_ZERO;
        PCMUX = PCMUX_ADDER; LD_PC = 1'b1;
        next_state = FETCH1;
      end
      JSR1: begin
        GatePC = 1'b1; DRMUX = 1'b1; LD_REG = 1'b1;
        next_state = JSR2;
      end
      // JSRR through R7 deliberately picks up the freshly written return address
      JSR2: begin
        if (IR[11]) begin
          ADDR2MUX = A2_OFF11;
        end else begin
          ADDR1MUX = 1'b1; SR1MUX = 1'b1;
        end
        PCMUX = PCMUX_ADDER; LD_PC = 1'b1;
        next_state = FETCH1;
      end
      LDR1, STR1: begin
        SR1MUX = 1'b1; ADDR1MUX = 1'b1; ADDR2MUX = A2_OFF6;
        GateMARMUX = 1'b1; LD_MAR = 1'b1;
        next_state = (state == LDR1) ? LDR2 : STR2;
      end
      LDR3: begin
        GateMDR = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
        next_state = FETCH1;
      end
      STR2: begin
        ALUK = ALUK_PASS; GateALU = 1'b1; LD_MDR = 1'b1;
        next_state = STR3;
      end
      STR3: begin
        Mem_WE_n = 1'b0;
        if (mem_done) next_state = FETCH1;
      end
      PAUSE1: begin
        LD_LED = 1'b1;
        if (Continue) next_state = PAUSE2;
      end
      PAUSE2: begin
        LD_LED = 1'b1;
        if (!Continue) next_state = FETCH1;
      end
      default: next_state = HALTED;
    endcase
  end

endmodule

// File: tb/tb_slc3_isdu.sv
// tb/tb_slc3_isdu.sv - scoreboard bench for slc3_isdu with an instruction-level model
module tb_slc3_isdu;

  localparam int MW = 2;

  logic Clk = 1'b0;
  logic Reset_n, Run, Continue, BEN;
  logic [15:0] IR;
  logic LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
  logic GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0] PCMUX, ADDR2MUX, ALUK;
  logic DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN, Mem_OE_n, Mem_WE_n;

  typedef struct packed {
    logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
    logic gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux;
    logic drmux, sr1mux, sr2mux, addr1mux;
    logic [1:0] addr2mux, aluk;
    logic mio_en, oe_n, we_n;
  } ctl_t;

  ctl_t  act;
  ctl_t  exp_q[$];
  string lbl_q[$];
  int    n_checks = 0;
  int    n_fail = 0;

  slc3_isdu #(.MEM_WAIT(MW)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Run(Run), .Continue(Continue), .IR(IR), .BEN(BEN),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN), .LD_CC(LD_CC),
    .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED), .GatePC(GatePC), .GateMDR(GateMDR),
    .GateALU(GateALU), .GateMARMUX(GateMARMUX), .PCMUX(PCMUX), .DRMUX(DRMUX),
    .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX),
    .ALUK(ALUK), .MIO_EN(MIO_EN), .Mem_OE_n(Mem_OE_n), .Mem_WE_n(Mem_WE_n)
  );

  assign act = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
                GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, DRMUX, SR1MUX, SR2MUX,
                ADDR1MUX, ADDR2MUX, ALUK, MIO_EN, Mem_OE_n, Mem_WE_n};

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Monitor: one expected control word per clock, compared mid-cycle
  initial begin
    forever begin
      @(negedge Clk);
      if (exp_q.size() > 0) begin
        ctl_t  e;
        string l;
        e = exp_q.pop_front();
        l = lbl_q.pop_front();
        check($sformatf("ctl[%s]", l), 32'(act), 32'(e));
        check($sformatf("one_gate[%s]", l),
              32'($countones({act.gate_pc, act.gate_mdr, act.gate_alu, act.gate_marmux}) <= 1), 32'd1);
        check($sformatf("strobes[%s]", l), 32'(act.oe_n | act.we_n), 32'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic ctl_t idle();
    ctl_t c = '0;
    c.oe_n = 1'b1;
    c.we_n = 1'b1;
    return c;
  endfunction

  task automatic cyc(input ctl_t w, input string nm);
    @(posedge Clk);
    #1;
    exp_q.push_back(w);
    lbl_q.push_back(nm);
  endtask

  task automatic mem_read(input string nm);
    ctl_t c;
    for (int i = 0; i < MW; i++) begin
      c = idle(); c.oe_n = 1'b0; c.mio_en = 1'b1; c.ld_mdr = (i == MW - 1);
      cyc(c, nm);
    end
  endtask

  task automatic fetch_decode(input logic [15:0] ir, input logic ben);
    ctl_t c;
    c = idle(); c.gate_pc = 1; c.ld_mar = 1; c.ld_pc = 1; c.pcmux = 2'b00;
    cyc(c, "fetch1");
    IR = ir; BEN = ben;
    mem_read("fetch2");
    c = idle(); c.gate_mdr = 1; c.ld_ir = 1; cyc(c, "fetch3");
    c = idle(); c.ld_ben = 1; cyc(c, "decode");
  endtask

  function automatic ctl_t addr_mar();
    ctl_t c = idle();
    c.sr1mux = 1; c.addr1mux = 1; c.addr2mux = 2'b01; c.gate_marmux = 1; c.ld_mar = 1;
    return c;
  endfunction

  // Reference model: full control-word sequence of one instruction starting at FETCH1
  task automatic exec(input logic [15:0] ir, input logic ben, input int pw, input int ph);
    ctl_t c;
    logic [3:0] op;
    op = ir[15:12];
    fetch_decode(ir, ben);
    case (op)
      4'b0001, 4'b0101, 4'b1001: begin
        c = idle(); c.sr1mux = 1; c.sr2mux = ir[5];
        c.aluk = (op == 4'b0001) ? 2'b00 : (op == 4'b0101) ? 2'b01 : 2'b10;
        c.gate_alu = 1; c.ld_reg = 1; c.ld_cc = 1;
        cyc(c, "alu");
      end
      4'b0000: begin
        cyc(idle(), "br0");
        if (ben) begin
          c = idle(); c.addr2mux = 2'b10; c.pcmux = 2'b10; c.ld_pc = 1;
          cyc(c, "br1");
        end
      end
      4'b1100: begin
        c = idle(); c.sr1mux = 1; c.addr1mux = 1; c.pcmux = 2'b10; c.ld_pc = 1;
        cyc(c, "jmp");
      end
      4'b0100: begin
        c = idle(); c.gate_pc = 1; c.drmux = 1; c.ld_reg = 1; cyc(c, "jsr1");
        c = idle(); c.pcmux = 2'b10; c.ld_pc = 1;
        if (ir[11]) c.addr2mux = 2'b11;
        else begin c.addr1mux = 1; c.sr1mux = 1; end
        cyc(c, "jsr2");
      end
      4'b0110: begin
        cyc(addr_mar(), "ldr1");
        mem_read("ldr2");
        c = idle(); c.gate_mdr = 1; c.ld_reg = 1; c.ld_cc = 1; cyc(c, "ldr3");
      end
      4'b0111: begin
        cyc(addr_mar(), "str1");
        c = idle(); c.aluk = 2'b11; c.gate_alu = 1; c.ld_mdr = 1; cyc(c, "str2");
        c = idle(); c.we_n = 1'b0;
        repeat (MW) cyc(c, "str3");
      end
      4'b1101: begin
        c = idle(); c.ld_led = 1;
        cyc(c, "pause1");
        repeat (pw) cyc(c, "pause1_wait");
        Continue = 1'b1;
        repeat (ph) cyc(c, "pause2_hold");
        Continue = 1'b0;
      end
      default: ;
    endcase
  endtask

  task automatic reset_mid_ldr();
    fetch_decode(16'h6283, 1'b0);
    cyc(addr_mar(), "ldr1");
    mem_read("ldr2");
    @(negedge Clk);
    #1;
    Reset_n = 1'b0;
    Run = 1'b0;
    #1;
    check("async_reset_ctl", 32'(act), 32'(idle()));
    check("async_reset_wait_cnt", 32'(dut.u_wait.wait_cnt), 32'd0);
    cyc(idle(), "in_reset");
    Reset_n = 1'b1;
    repeat (2) cyc(idle(), "halted_after_reset");
    Run = 1'b1;
  endtask

  initial begin
    logic [15:0] rir;
    Reset_n = 1'b0; Run = 1'b0; Continue = 1'b0; BEN = 1'b0; IR = 16'h0000;
    repeat (2) cyc(idle(), "reset");
    Reset_n = 1'b1;
    repeat (5) cyc(idle(), "halted");
    Run = 1'b1;

    exec(16'h1283, 1'b0, 0, 1);
    exec(16'h0E05, 1'b1, 0, 1);
    exec(16'h0E05, 1'b0, 0, 1);
    exec(16'h7283, 1'b0, 0, 1);
    exec(16'hD0AA, 1'b0, 2, 10);
    exec(16'h5283, 1'b0, 0, 1);
    exec(16'h9A7F, 1'b0, 0, 1);
    exec(16'hC080, 1'b0, 0, 1);
    exec(16'h4800, 1'b0, 0, 1);
    exec(16'h41C0, 1'b0, 0, 1);
    exec(16'h6283, 1'b0, 0, 1);
    exec(16'h8000, 1'b0, 0, 1);
    exec(16'hF025, 1'b1, 0, 1);

    for (int i = 0; i < 40; i++) begin
      rir = 16'($urandom);
      exec(rir, 1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(1, 4)));
    end

    reset_mid_ldr();
    exec(16'h1283, 1'b0, 0, 1);

    @(negedge Clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
